// File: rtl/ndro_access_sched.sv
// Access scheduler for one NDRO cell: arbitrates write/read requesters, spaces the
// set/reset/clk pulses, captures the readout window and flags shadow mismatches.
module ndro_access_sched #(
    parameter int unsigned SETUP_CYC = 3,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned READ_WIN  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_valid,
    input  logic wr_data,
    output logic wr_ready,
    input  logic rd_valid,
    output logic rd_ready,
    output logic rd_data_valid,
    output logic rd_data,
    output logic ndro_set,
    output logic ndro_reset,
    output logic ndro_clk,
    input  logic ndro_out,
    output logic stored,
    output logic err_mismatch
);

    typedef enum logic [2:0] {
        IDLE,
        WPULSE,
        SETTLE,
        RPULSE,
        RSAMPLE,
        RHOLD
    } state_t;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] SAMP_LD  = 8'((READ_WIN > 1) ? READ_WIN - 2 : 0);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       last_rd;
    logic       acc;
    logic       idle;
    logic       wr_acc;
    logic       rd_acc;

    assign idle     = (state == IDLE);
    assign wr_ready = idle & (~rd_valid | last_rd);
    assign rd_ready = idle & (~wr_valid | ~last_rd);
    assign wr_acc   = wr_valid & wr_ready;
    assign rd_acc   = rd_valid & rd_ready;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        ndro_set      = 1'b0;
        ndro_reset    = 1'b0;
        ndro_clk      = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = 1'b0;
        case (state)
            IDLE: begin
                if (wr_acc) begin
                    state_n = WPULSE;
                end else if (rd_acc) begin
                    state_n = RPULSE;
                end
            end
            WPULSE: begin
                ndro_set   = stored;
                ndro_reset = ~stored;
                state_n    = SETTLE;
                cnt_n      = SETUP_LD;
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            RPULSE: begin
                ndro_clk = 1'b1;
                if (READ_WIN == 1) begin
                    state_n = RHOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    state_n = RSAMPLE;
                    cnt_n   = SAMP_LD;
                end
            end
            RSAMPLE: begin
                if (cnt == '0) begin
                    state_n = RHOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            RHOLD: begin
                // counter still holds its load value only in the first hold cycle
                rd_data_valid = (cnt == HOLD_LD);
                rd_data       = (cnt == HOLD_LD) & acc;
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_rd      <= 1'b1;
            acc          <= 1'b0;
            stored       <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (wr_acc) begin
                stored  <= wr_data;
                last_rd <= 1'b0;
            end
            if (rd_acc) begin
                last_rd <= 1'b1;
            end
            if (state == RPULSE) begin
                acc <= ndro_out;
            end else if (state == RSAMPLE) begin
                acc <= acc | ndro_out;
            end
            if (rd_data_valid && (acc != stored)) begin
                err_mismatch <= 1'b1;
            end
        end
    end

endmodule
